// File: rtl/i2s_stereo_tx.sv
// Stereo I2S / left-justified serializer: s_clk, LR_clk and data_out are clk-domain registers; a frame starts 2*SCLK_DIV clk after enable.
// One-entry sample buffer (s_ready = buffer empty), reloaded at each frame start; silence and an underrun pulse when it is empty.
module i2s_stereo_tx #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 16,
    parameter int SCLK_DIV = 8,
    parameter int MODE     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              m_clk,
    output logic              s_clk,
    output logic              LR_clk,
    output logic              data_out,
    output logic              underrun
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int K_W     = $clog2(FRAME_W);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCLK_DIV - 1);
    localparam logic [K_W-1:0]   K_LAST  = K_W'(FRAME_W - 1);
    localparam logic [K_W-1:0]   K_SLOT  = K_W'(SLOT_W);
    localparam logic [K_W-1:0]   K_PRE   = K_W'(SLOT_W - 1);

    generate
        if (DATA_W < 8 || DATA_W > 32) begin : g_bad_data_w
            $error("DATA_W must be within 8..32");
        end
        if (SLOT_W < DATA_W) begin : g_bad_slot_w
            $error("SLOT_W must be >= DATA_W");
        end
        if (SCLK_DIV < 1) begin : g_bad_div
            $error("SCLK_DIV must be >= 1");
        end
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $error("MODE must be 0 or 1");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               sclk_q, sclk_d, lr_q, lr_d, dout_q, dout_d, und_q, und_d;
    logic               full_q, full_d, mclk_q, rdy_q;
    logic [DATA_W-1:0]  buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [FRAME_W-1:0] sh_q, sh_d, frame_w;
    logic               tick, fall, load;

    function automatic logic [SLOT_W-1:0] slot_word(input logic [DATA_W-1:0] s);
        return SLOT_W'(s) << (SLOT_W - DATA_W);
    endfunction

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        k_d     = k_q;
        sclk_d  = sclk_q;
        lr_d    = lr_q;
        dout_d  = dout_q;
        und_d   = 1'b0;
        full_d  = full_q;
        buf_l_d = buf_l_q;
        buf_r_d = buf_r_q;
        sh_d    = sh_q;
        frame_w = sh_q;
        tick    = (div_q == DIV_MAX);
        fall    = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                k_d    = '0;
                sclk_d = 1'b0;
                lr_d   = 1'b0;
                dout_d = 1'b0;
                if (en) state_d = ST_RUN;
            end
            default: begin
                state_d = en ? ST_RUN : ST_DRAIN;
                div_d   = tick ? '0 : div_q + 1'b1;
                if (tick) sclk_d = ~sclk_q;
                fall = tick && sclk_q;
                // A draining frame ends where the next one would have been loaded.
                if (fall && k_q == '0 && state_q == ST_DRAIN && !en) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    k_d     = '0;
                    sclk_d  = 1'b0;
                    lr_d    = 1'b0;
                    dout_d  = 1'b0;
                end else if (fall) begin
                    load = (k_q == '0);
                    if (load) begin
                        frame_w = full_q ? {slot_word(buf_l_q), slot_word(buf_r_q)} : '0;
                        full_d  = 1'b0;
                        und_d   = ~full_q;
                    end
                    dout_d = frame_w[FRAME_W-1];
                    sh_d   = frame_w << 1;
                    lr_d   = (MODE == 1) ? (k_q >= K_SLOT) : (k_q != K_LAST && k_q >= K_PRE);
                    k_d    = (k_q == K_LAST) ? '0 : k_q + 1'b1;
                end
            end
        endcase
        // An accept can only happen while empty, so it never collides with a real transfer.
        if (s_valid && s_ready) begin
            full_d  = 1'b1;
            buf_l_d = s_left;
            buf_r_d = s_right;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            k_q     <= '0;
            sclk_q  <= 1'b0;
            lr_q    <= 1'b0;
            dout_q  <= 1'b0;
            und_q   <= 1'b0;
            full_q  <= 1'b0;
            buf_l_q <= '0;
            buf_r_q <= '0;
            sh_q    <= '0;
            mclk_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            k_q     <= k_d;
            sclk_q  <= sclk_d;
            lr_q    <= lr_d;
            dout_q  <= dout_d;
            und_q   <= und_d;
            full_q  <= full_d;
            buf_l_q <= buf_l_d;
            buf_r_q <= buf_r_d;
            sh_q    <= sh_d;
            mclk_q  <= ~mclk_q;
            rdy_q   <= 1'b1;
        end
    end

    assign s_ready  = rdy_q & ~full_q;
    assign m_clk    = mclk_q;
    assign s_clk    = sclk_q;
    assign LR_clk   = lr_q;
    assign data_out = dout_q;
    assign underrun = und_q;
endmodule

// File: doc/i2s_stereo_tx.md
I2S_STEREO_TX -- requirements
Module: i2s_stereo_tx

Interface
REQ-001 Parameter DATA_W, default 16: sample width per channel, 8..32.
REQ-002 Parameter SLOT_W, default 16: SCLK periods per channel slot; SLOT_W >= DATA_W (elaboration error otherwise).
REQ-003 Parameter SCLK_DIV, default 8: clk cycles per SCLK half-period, >= 1.
REQ-004 Parameter MODE, default 0: 0 = Philips I2S (one-bit delay), 1 = left-justified.
REQ-005 clk  in  1  system clock, sole clock; all state on posedge clk.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  transmit enable.
REQ-008 s_valid  in  1  stereo sample pair valid.
REQ-009 s_ready  out  1  block can accept a pair this cycle.
REQ-010 s_left  in  DATA_W  left sample, two's complement.
REQ-011 s_right  in  DATA_W  right sample, two's complement.
REQ-012 m_clk  out  1  master clock, clk/2.
REQ-013 s_clk  out  1  serial bit clock.
REQ-014 LR_clk  out  1  word select; 0 = left, 1 = right.
REQ-015 data_out  out  1  serial data, MSB first.
REQ-016 underrun  out  1  one-clk pulse: frame started with no buffered pair.

Function
REQ-017 No derived clocks: s_clk, LR_clk, data_out shall be registers updated on clk via a divider tick.
REQ-018 Divider counts 0..SCLK_DIV-1 while running; at SCLK_DIV-1 it wraps and s_clk toggles.
REQ-019 All LR_clk/data_out/bit counter updates shall occur in the clk cycle s_clk goes 1->0 ("fall tick").
REQ-020 Bit counter k counts 0..2*SLOT_W-1 on fall ticks, wrapping to 0; k=0 is frame start.
REQ-021 After a fall tick with counter k: MODE=1 -> LR_clk = (k >= SLOT_W); MODE=0 -> LR_clk = (((k+1) mod 2*SLOT_W) >= SLOT_W).
REQ-022 Slot word = sample in upper DATA_W bits, zero-padded below; data_out = slot word bit (SLOT_W-1-(k mod SLOT_W)), left slot for k < SLOT_W, right otherwise.
REQ-023 One-entry holding buffer: s_ready = ~buffer_full; s_valid && s_ready captures s_left/s_right and sets buffer_full next cycle.
REQ-024 At each frame-start fall tick: if buffer_full, copy to shift registers and clear buffer_full (s_ready high next cycle); else load zeros and pulse underrun for exactly that cycle.
REQ-025 Accept on the same cycle as a frame-start transfer shall refill the buffer without loss.
REQ-026 States IDLE, RUN, DRAIN. IDLE: divider/counter held 0, s_clk=0, LR_clk=0, data_out=0; buffer still accepts.
REQ-027 IDLE->RUN when en=1; first fall tick occurs 2*SCLK_DIV clk cycles later with k=0.
REQ-028 RUN->DRAIN when en=0; DRAIN completes the current frame and enters IDLE on the fall tick that would set k=0, with no load and no underrun.
REQ-029 en reasserted in DRAIN returns to RUN without disturbing timing.
REQ-030 m_clk toggles every clk cycle regardless of state.

Reset
REQ-031 rst asserted, at any time, asynchronously forces: IDLE, counters 0, buffer empty, m_clk=0, s_clk=0, LR_clk=0, data_out=0, underrun=0, s_ready=0.
REQ-032 s_ready shall go high on the first clk edge after rst deasserts; a frame interrupted by rst is discarded.

Verification (DATA_W=16, SLOT_W=16, SCLK_DIV=2 unless noted)
REQ-033 Push L=0xA5C3, R=0x0F01, en=1 -> s_clk period 4 clk; left slot shifts 1010010111000011 MSB first, LR_clk falls one s_clk before left MSB (MODE=0).
REQ-034 MODE=1, same data -> LR_clk edges coincide with MSB of each slot; 32 s_clk per frame.
REQ-035 SLOT_W=24, L=0x8001 -> data_out 1000000000000001 then eight 0 bits.
REQ-036 en=1, no s_valid -> all-zero frames, one underrun pulse per frame start; push mid-frame -> sent next frame, no underrun then.
REQ-037 Continuous s_valid -> s_ready high one clk after each frame start, back-to-back frames, no underrun, no sample loss.
REQ-038 en dropped at k=5 -> frame finishes to k=31, outputs go 0 in IDLE; rst at k=10 -> all outputs 0 immediately.
